// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle MIPS control unit driving ALU selector, operand muxes and memory/PC/regfile strobes.
// Define ILLEGAL_TRAP_EN to make S_ILLEGAL terminal until reset; otherwise it is a timed NOP back to fetch.
module alu_control_fsm #(
    parameter int COUNT_WIDTH        = 32,
    parameter int ILLEGAL_NOP_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zeroFlag,
    input  logic                   mem_ready,
    output logic [1:0]             selector,
    output logic                   alu_src_A,
    output logic [1:0]             alu_src_B,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   illegal
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_I_EXEC    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_ILLEGAL   = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;

    logic [3:0] next_state;
    logic       retire;
    logic       funct_ok;
    logic [1:0] r_sel;
    logic       illegal_done;
    logic       unused_zero;

    // zeroFlag gates the PC in the datapath together with pc_write_cond
    assign unused_zero = zeroFlag;
    assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) || (funct == F_OR);
    assign r_sel = (funct == F_SUB) ? 2'b01 : (funct == F_AND) ? 2'b10 : (funct == F_OR) ? 2'b11 : 2'b00;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_done = 1'b0;
`else
    localparam int NW = $clog2(ILLEGAL_NOP_CYCLES + 1);
    logic [NW-1:0] nop_cnt;
    assign illegal_done = nop_cnt == NW'(ILLEGAL_NOP_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset || state != S_ILLEGAL)
            nop_cnt <= '0;
        else
            nop_cnt <= nop_cnt + NW'(1);
    end
`endif

    always_comb begin
        next_state = state;
        retire = 1'b0;
        case (state)
            S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    next_state = (opcode == OP_R) ? S_R_EXEC :
                                      (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                                      (opcode == OP_BEQ) ? S_BRANCH :
                                      (opcode == OP_ADDI) ? S_I_EXEC :
                                      (opcode == OP_J) ? S_JUMP : S_ILLEGAL;
            S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire = mem_ready;
            end
            S_R_EXEC:    next_state = funct_ok ? S_R_WB : S_ILLEGAL;
            S_I_EXEC:    next_state = S_I_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
                next_state = S_FETCH;
                retire = 1'b1;
            end
            S_ILLEGAL:   next_state = illegal_done ? S_FETCH : S_ILLEGAL;
            default:     next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

    // every control output is held low while reset is asserted
    always_comb begin
        selector = 2'b00;
        alu_src_A = 1'b0;
        alu_src_B = 2'b00;
        i_or_d = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        pc_source = 2'b00;
        reg_dst = 1'b0;
        mem_to_reg = 1'b0;
        reg_write = 1'b0;
        illegal = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    alu_src_B = 2'b01;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE:    alu_src_B = 2'b11;
                S_MEM_ADDR, S_I_EXEC: begin
                    alu_src_A = 1'b1;
                    alu_src_B = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_A = 1'b1;
                    selector = r_sel;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_A = 1'b1;
                    selector = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source = 2'b01;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_source = 2'b10;
                end
                S_I_WB:      reg_write = 1'b1;
                S_ILLEGAL:   illegal = 1'b1;
                default:     illegal = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_fsm.sv
// tb_alu_control_fsm: builds per-instruction expected state paths from the ISA rules and compares each cycle.
module tb_alu_control_fsm;
    localparam int ILL_N = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zeroFlag = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] selector, alu_src_B, pc_source;
    logic       alu_src_A, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    logic [3:0] state;
    logic [3:0] instr_count;
    logic [16:0] ctl;

    alu_control_fsm #(.COUNT_WIDTH(4), .ILLEGAL_NOP_CYCLES(ILL_N)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zeroFlag(zeroFlag),
        .mem_ready(mem_ready), .selector(selector), .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state),
        .instr_count(instr_count), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign ctl = {selector, alu_src_A, alu_src_B, i_or_d, mem_read, mem_write, ir_write, pc_write,
                  pc_write_cond, pc_source, reg_dst, mem_to_reg, reg_write, illegal};

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [3:0]  cnt;
    } obs_t;
    typedef struct packed {
        obs_t       ex;
        logic       rdy;
        logic       zf;
        logic [5:0] op;
        logic [5:0] fn;
    } step_t;

    step_t      exp_q[$];
    obs_t       obs_q[$];
    logic [3:0] exp_cnt = '0;
    int         n_vec = 0;
    int         n_err = 0;

    // control word each state must present, straight from the state descriptions
    function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic [5:0] fn);
        logic [1:0] sel = 0, srcb = 0, psrc = 0;
        logic srca = 0, iod = 0, mr = 0, mw = 0, irw = 0, pcw = 0, pcc = 0, rd = 0, m2r = 0, rw = 0, ill = 0;
        case (st)
            4'd0: begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1: srcb = 2'b11;
            4'd2: begin srca = 1; srcb = 2'b10; end
            4'd3: begin mr = 1; iod = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin mw = 1; iod = 1; end
            4'd6: begin srca = 1; sel = fn == 6'h22 ? 2'b01 : fn == 6'h24 ? 2'b10 : fn == 6'h25 ? 2'b11 : 2'b00; end
            4'd7: begin rw = 1; rd = 1; end
            4'd8: begin srca = 1; sel = 2'b01; pcc = 1; psrc = 2'b01; end
            4'd9: begin pcw = 1; psrc = 2'b10; end
            4'd10: begin srca = 1; srcb = 2'b10; end
            4'd11: rw = 1;
            4'd12: ill = 1;
            default: ill = 0;
        endcase
        return {sel, srca, srcb, iod, mr, mw, irw, pcw, pcc, psrc, rd, m2r, rw, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op, input logic [5:0] fn, input logic zf);
        step_t s;
        s.ex.st = st;
        s.ex.ctl = exp_ctl(st, rdy, fn);
        s.ex.cnt = exp_cnt;
        s.rdy = rdy;
        s.zf = zf;
        s.op = op;
        s.fn = fn;
        exp_q.push_back(s);
    endtask

    task automatic push_illegal(input logic [5:0] op, input logic [5:0] fn, input logic zf);
`ifdef ILLEGAL_TRAP_EN
        push(4'd12, 1'($urandom), op, fn, zf);
`else
        repeat (ILL_N) push(4'd12, 1'($urandom), op, fn, zf);
`endif
    endtask

    // reference: the state path of one instruction, with memory wait cycles
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int w0, input int w1, input logic zf);
        logic ret;
        logic [3:0] ms;
        ret = 1'b1;
        ms = (op == 6'h23) ? 4'd3 : 4'd5;
        repeat (w0) push(4'd0, 1'b0, op, fn, zf);
        push(4'd0, 1'b1, op, fn, zf);
        push(4'd1, 1'($urandom), op, fn, zf);
        if (op == 6'h00) begin
            push(4'd6, 1'($urandom), op, fn, zf);
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25}) push(4'd7, 1'($urandom), op, fn, zf);
            else begin push_illegal(op, fn, zf); ret = 1'b0; end
        end else if (op == 6'h23 || op == 6'h2B) begin
            push(4'd2, 1'($urandom), op, fn, zf);
            repeat (w1) push(ms, 1'b0, op, fn, zf);
            push(ms, 1'b1, op, fn, zf);
            if (op == 6'h23) push(4'd4, 1'($urandom), op, fn, zf);
        end else if (op == 6'h04) push(4'd8, 1'($urandom), op, fn, zf);
        else if (op == 6'h02) push(4'd9, 1'($urandom), op, fn, zf);
        else if (op == 6'h08) begin
            push(4'd10, 1'($urandom), op, fn, zf);
            push(4'd11, 1'($urandom), op, fn, zf);
        end else begin
            push_illegal(op, fn, zf);
            ret = 1'b0;
        end
        if (ret) exp_cnt++;
    endtask

    task automatic play;
        obs_q.delete();
        foreach (exp_q[i]) begin
            @(negedge clock);
            opcode = exp_q[i].op;
            funct = exp_q[i].fn;
            mem_ready = exp_q[i].rdy;
            zeroFlag = exp_q[i].zf;
            #1;
            obs_q.push_back({state, ctl, instr_count});
        end
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset;
        repeat (3) begin
            @(negedge clock);
            mem_ready = 1'($urandom);
            #1;
            n_vec++;
            if (state !== 4'd0 || ctl !== 17'h0 || instr_count !== 4'd0) begin
                n_err++;
                $display("FAIL reset: state=%0d ctl=%h cnt=%0d, want 0/0/0", state, ctl, instr_count);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        mem_ready = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_r_type;
        exp_q.delete();
        add_instr(6'h00, 6'h22, 0, 0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL r_type step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        n_vec++;
        if (state !== 4'd0 || instr_count !== 4'd1) begin
            n_err++;
            $display("FAIL r_type end: state=%0d cnt=%0d want 0/1", state, instr_count);
        end
    endtask

    task automatic test_lw_wait;
        exp_q.delete();
        add_instr(6'h23, 6'h00, 2, 3, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL lw_wait step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        n_vec++;
        if (state !== 4'd0 || instr_count !== exp_cnt) begin
            n_err++;
            $display("FAIL lw_wait end: state=%0d cnt=%0d want 0/%0d", state, instr_count, exp_cnt);
        end
    endtask

    task automatic test_beq;
        exp_q.delete();
        add_instr(6'h04, 6'h00, 0, 0, 1'b1);
        add_instr(6'h04, 6'h00, 1, 0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL beq step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        n_vec++;
        if (state !== 4'd0 || instr_count !== exp_cnt) begin
            n_err++;
            $display("FAIL beq end: state=%0d cnt=%0d want 0/%0d", state, instr_count, exp_cnt);
        end
    endtask

    task automatic test_illegal;
        exp_q.delete();
        add_instr(6'h3F, 6'h00, 0, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        add_instr(6'h00, 6'h3F, 0, 0, 1'b0);
`endif
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL illegal step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
`ifdef ILLEGAL_TRAP_EN
        repeat (20) begin
            @(negedge clock); mem_ready = 1'($urandom); #1;
            n_vec++;
            if (state !== 4'd12 || illegal !== 1'b1 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL illegal trap: state=%0d illegal=%b cnt=%0d want 12/1/%0d", state, illegal, instr_count, exp_cnt);
            end
        end
        do_reset();
`else
        @(negedge clock); mem_ready = 1'b0; #1;
        n_vec++;
        if (state !== 4'd0 || instr_count !== exp_cnt || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL illegal end: state=%0d cnt=%0d illegal=%b want 0/%0d/0", state, instr_count, illegal, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        exp_q.delete();
        add_instr(6'h2B, 6'h00, 0, 4, 1'b0);
        while (exp_q[$].rdy) void'(exp_q.pop_back());
        exp_cnt = '0;
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL mid_write step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
        @(negedge clock); reset = 1'b1; mem_ready = 1'b1; #1;
        n_vec++;
        if (mem_write !== 1'b0 || ctl !== 17'h0) begin
            n_err++;
            $display("FAIL mid_write forced: mem_write=%b ctl=%h want 0/0", mem_write, ctl);
        end
        repeat (3) begin
            @(negedge clock); mem_ready = 1'($urandom); #1;
            n_vec++;
            if (state !== 4'd0 || ctl !== 17'h0 || instr_count !== 4'd0) begin
                n_err++;
                $display("FAIL mid_write held: state=%0d ctl=%h cnt=%0d want 0/0/0", state, ctl, instr_count);
            end
        end
        @(negedge clock); reset = 1'b0; mem_ready = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_jump_wrap;
        do_reset();
        exp_q.delete();
        repeat (16) add_instr(6'h02, 6'($urandom), 0, 0, 1'($urandom));
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL jump_wrap step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        n_vec++;
        if (state !== 4'd0 || instr_count !== 4'd0) begin
            n_err++;
            $display("FAIL jump_wrap end: state=%0d cnt=%0d want 0/0", state, instr_count);
        end
    endtask

    task automatic test_random;
        logic [5:0] legal_op[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        logic [5:0] legal_fn[4] = '{6'h20, 6'h22, 6'h24, 6'h25};
        logic [5:0] op, fn;
        exp_q.delete();
        repeat (40) begin
            op = legal_op[$urandom_range(0, 5)];
            fn = legal_fn[$urandom_range(0, 3)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
`endif
            add_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end
        play();
        foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i].ex) begin
                n_err++;
                $display("FAIL random step %0d: got %h want %h", i, obs_q[i], exp_q[i].ex);
            end
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        n_vec++;
        if (state !== 4'd0 || instr_count !== exp_cnt) begin
            n_err++;
            $display("FAIL random end: state=%0d cnt=%0d want 0/%0d", state, instr_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_reset_mid_write();
        test_jump_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
